pipe_em_stage: RTL and testbench

//   Parametrised EXE/MEM pipeline stage with valid/ready handshake, stall, flush and a skid slot.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_slot.sv | 61 ++++++
 rtl/pipe_em_stage.sv | 161 ++++++++++++++++
 tb/tb_pipe_em_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg : shared types and defaults for the EXE/MEM pipeline stage
// Rev 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned RW_DEFAULT = 5;

    typedef struct packed {
        logic wreg;
        logic m2reg;
        logic wmem;
    } em_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_st_e;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_slot : one pipeline entry (control, ALU result, store data, dest reg)
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          valid_i,
    input  em_ctrl_t      ctrl_i,
    input  logic [DW-1:0] alu_i,
    input  logic [DW-1:0] b_i,
    input  logic [RW-1:0] rn_i,
    output logic          valid_o,
    output em_ctrl_t      ctrl_o,
    output logic [DW-1:0] alu_o,
    output logic [DW-1:0] b_o,
    output logic [RW-1:0] rn_o
);

    logic          valid_q;
    em_ctrl_t      ctrl_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] b_q;
    logic [RW-1:0] rn_q;

    // Clear kills only valid and control; data is left stale on purpose.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            b_q     <= '0;
            rn_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            ctrl_q  <= ctrl_i & {3{valid_i}};
            alu_q   <= alu_i;
            b_q     <= b_i;
            rn_q    <= rn_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign alu_o   = alu_q;
    assign b_o     = b_q;
    assign rn_o    = rn_q;

endmodule
`default_nettype wire

// File: rtl/pipe_em_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_em_stage : EXE/MEM stage with valid/ready handshake, flush and skid slot
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_em_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned RW      = RW_DEFAULT,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          flush,
    input  logic          e_valid,
    output logic          e_ready,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic          ewmem,
    input  logic [DW-1:0] eAlu,
    input  logic [DW-1:0] eb,
    input  logic [RW-1:0] ern,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          mwreg,
    output logic          mm2reg,
    output logic          mwmem,
    output logic [DW-1:0] mAlu,
    output logic [DW-1:0] mB,
    output logic [RW-1:0] mrn
);

    stage_st_e     state_q, state_d;
    logic          w_in, w_out;
    logic          main_load, main_from_skid, main_clr, skid_load, skid_clr;

    em_ctrl_t      e_ctrl, skid_ctrl, main_ctrl, mux_ctrl;
    logic          skid_valid, main_valid, mux_valid;
    logic [DW-1:0] skid_alu, skid_b, mux_alu, mux_b;
    logic [RW-1:0] skid_rn, mux_rn;

    assign e_ctrl = {ewreg, em2reg, ewmem};
    assign w_in   = e_valid & e_ready;
    assign w_out  = m_valid & m_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_in) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (w_in && w_out) begin
                        main_load = 1'b1;
                    end else if (w_in && SKID_EN) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end else if (w_out) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                SKID: begin
                    // Skid holds the younger beat; it moves up as main drains.
                    if (w_out) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid_ready
            logic e_ready_q;
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    e_ready_q <= 1'b1;
                end else begin
                    e_ready_q <= (state_d != SKID);
                end
            end
            assign e_ready = e_ready_q;
        end else begin : g_comb_ready
            assign e_ready = (state_q == EMPTY) | m_ready;
        end
    endgenerate

    assign mux_valid = main_from_skid ? skid_valid : e_valid;
    assign mux_ctrl  = main_from_skid ? skid_ctrl  : e_ctrl;
    assign mux_alu   = main_from_skid ? skid_alu   : eAlu;
    assign mux_b     = main_from_skid ? skid_b     : eb;
    assign mux_rn    = main_from_skid ? skid_rn    : ern;

    pipe_slot #(.DW(DW), .RW(RW)) u_skid (
        .clock   (clock),
        .resetn  (resetn),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .valid_i (e_valid),
        .ctrl_i  (e_ctrl),
        .alu_i   (eAlu),
        .b_i     (eb),
        .rn_i    (ern),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .alu_o   (skid_alu),
        .b_o     (skid_b),
        .rn_o    (skid_rn)
    );

    pipe_slot #(.DW(DW), .RW(RW)) u_main (
        .clock   (clock),
        .resetn  (resetn),
        .load_i  (main_load),
        .clear_i (main_clr),
        .valid_i (mux_valid),
        .ctrl_i  (mux_ctrl),
        .alu_i   (mux_alu),
        .b_i     (mux_b),
        .rn_i    (mux_rn),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .alu_o   (mAlu),
        .b_o     (mB),
        .rn_o    (mrn)
    );

    assign m_valid = main_valid;
    assign mwreg   = main_ctrl.wreg;
    assign mm2reg  = main_ctrl.m2reg;
    assign mwmem   = main_ctrl.wmem;

endmodule
`default_nettype wire

// File: tb/tb_pipe_em_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_em_stage : scoreboard bench for skid and non-skid builds
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_em_stage;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        int          cyc;
        bit          lat;
    } beat_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int failures = 0;

    beat_t q1[$];
    beat_t q0[$];

    // skid build signals
    logic        flush1 = 0, e1_valid = 0, e1_wreg = 0, e1_m2reg = 0, e1_wmem = 0, m1_ready = 0;
    logic [31:0] e1_alu = 0, e1_b = 0;
    logic [4:0]  e1_rn = 0;
    logic        e1_ready, m1_valid, m1_wreg, m1_m2reg, m1_wmem;
    logic [31:0] m1_alu, m1_b;
    logic [4:0]  m1_rn;

    // single-entry build signals
    logic        flush0 = 0, e0_valid = 0, e0_wreg = 0, e0_m2reg = 0, e0_wmem = 0, m0_ready = 0;
    logic [31:0] e0_alu = 0, e0_b = 0;
    logic [4:0]  e0_rn = 0;
    logic        e0_ready, m0_valid, m0_wreg, m0_m2reg, m0_wmem;
    logic [31:0] m0_alu, m0_b;
    logic [4:0]  m0_rn;

    pipe_em_stage #(.DW(32), .RW(5), .SKID_EN(1'b1)) dut (
        .clock(clock), .resetn(resetn), .flush(flush1),
        .e_valid(e1_valid), .e_ready(e1_ready),
        .ewreg(e1_wreg), .em2reg(e1_m2reg), .ewmem(e1_wmem),
        .eAlu(e1_alu), .eb(e1_b), .ern(e1_rn),
        .m_valid(m1_valid), .m_ready(m1_ready),
        .mwreg(m1_wreg), .mm2reg(m1_m2reg), .mwmem(m1_wmem),
        .mAlu(m1_alu), .mB(m1_b), .mrn(m1_rn)
    );

    pipe_em_stage #(.DW(32), .RW(5), .SKID_EN(1'b0)) dut0 (
        .clock(clock), .resetn(resetn), .flush(flush0),
        .e_valid(e0_valid), .e_ready(e0_ready),
        .ewreg(e0_wreg), .em2reg(e0_m2reg), .ewmem(e0_wmem),
        .eAlu(e0_alu), .eb(e0_b), .ern(e0_rn),
        .m_valid(m0_valid), .m_ready(m0_ready),
        .mwreg(m0_wreg), .mm2reg(m0_m2reg), .mwmem(m0_wmem),
        .mAlu(m0_alu), .mB(m0_b), .mrn(m0_rn)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", nm);
    endtask

    function automatic beat_t mk(input logic [31:0] v);
        beat_t t;
        t.ctrl = v[2:0];
        t.alu  = v;
        t.b    = v ^ 32'h5A5A_0000;
        t.rn   = v[4:0] ^ 5'h1F;
        t.cyc  = 0;
        t.lat  = 1'b0;
        return t;
    endfunction

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic drive1(input bit v, input beat_t bt, input bit mr, input bit fl, input bit lat);
        beat_t p;
        e1_valid = v;
        {e1_wreg, e1_m2reg, e1_wmem} = bt.ctrl;
        e1_alu = bt.alu; e1_b = bt.b; e1_rn = bt.rn;
        m1_ready = mr; flush1 = fl;
        @(negedge clock);
        if (v && e1_ready && !fl) begin
            p = bt; p.cyc = cyc_cnt; p.lat = lat;
            q1.push_back(p);
        end
        @(posedge clock); #1;
    endtask

    task automatic check_reset1(input string nm);
        chk({nm, "_m_valid"}, m1_valid, 0);
        chk({nm, "_ctrl"}, {m1_wreg, m1_m2reg, m1_wmem}, 0);
        chk({nm, "_data"}, {m1_alu, m1_b, m1_rn}, 0);
        chk({nm, "_e_ready"}, e1_ready, 1);
        chk({nm, "_m_valid0"}, m0_valid, 0);
    endtask

    always @(negedge clock) begin
        beat_t w;
        if (!m1_valid) chk("bubble_ctrl", {m1_wreg, m1_m2reg, m1_wmem}, 0);
        if (resetn && m1_valid && m1_ready) begin
            if (q1.size() == 0) fail("unexpected_beat");
            else begin
                w = q1.pop_front();
                chk("mAlu", m1_alu, w.alu);
                chk("mB", m1_b, w.b);
                chk("mrn", m1_rn, w.rn);
                chk("mctrl", {m1_wreg, m1_m2reg, m1_wmem}, w.ctrl);
                if (w.lat) chk("latency", cyc_cnt, w.cyc + 1);
            end
        end
    end

    always @(negedge clock) begin
        beat_t w;
        if (!m0_valid) chk("bubble_ctrl0", {m0_wreg, m0_m2reg, m0_wmem}, 0);
        if (resetn && m0_valid && m0_ready) begin
            if (q0.size() == 0) fail("unexpected_beat0");
            else begin
                w = q0.pop_front();
                chk("mAlu0", m0_alu, w.alu);
                chk("mB0", m0_b, w.b);
                chk("mrn0", m0_rn, w.rn);
                chk("mctrl0", {m0_wreg, m0_m2reg, m0_wmem}, w.ctrl);
            end
        end
    end

    initial begin
        beat_t idle;
        beat_t p;
        int idx;
        int n;
        idle = mk(32'h0);

        repeat (2) @(posedge clock);
        #1;
        check_reset1("reset_init");
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("ready_after_release", e1_ready, 1);

        // streaming: 1..8 back to back
        for (int i = 1; i <= 8; i++) drive1(1, mk(i), 1, 0, 1);
        repeat (2) drive1(0, idle, 1, 0, 0);
        chk("stream_drained", q1.size(), 0);

        // stall: 0xA, 0xB fill main and skid
        drive1(1, mk(32'hA), 0, 0, 0);
        chk("stall_ready_full", e1_ready, 1);
        drive1(1, mk(32'hB), 0, 0, 0);
        chk("stall_ready_skid", e1_ready, 0);
        drive1(1, mk(32'hC), 0, 0, 0);
        chk("stall_hold_alu", m1_alu, 32'hA);
        repeat (3) drive1(0, idle, 1, 0, 0);
        chk("stall_drained", q1.size(), 0);

        // bubbles with write controls asserted
        p = mk(32'h0); p.ctrl = 3'b101;
        for (int i = 0; i < 4; i++) begin
            drive1(0, p, i[0], 0, 0);
            chk("bubble_valid", m1_valid, 0);
            chk("bubble_wreg_wmem", {m1_wreg, m1_wmem}, 0);
        end

        // flush while in SKID with a store beat presented
        drive1(1, mk(32'h11), 0, 0, 0);
        drive1(1, mk(32'h12), 0, 0, 0);
        chk("flush_pre_ready", e1_ready, 0);
        drive1(1, mk(32'h13), 0, 1, 0);
        chk("flush_m_valid", m1_valid, 0);
        chk("flush_mwmem", m1_wmem, 0);
        chk("flush_e_ready", e1_ready, 1);
        q1.delete();
        drive1(1, mk(32'h14), 1, 0, 1);
        repeat (3) drive1(0, idle, 1, 0, 0);
        chk("flush_drained", q1.size(), 0);

        // asynchronous reset mid-transfer
        drive1(1, mk(32'h21), 0, 0, 0);
        drive1(1, mk(32'h22), 0, 0, 0);
        resetn = 1'b0;
        #1;
        check_reset1("reset_mid");
        q1.delete();
        drive1(0, idle, 1, 0, 0);
        resetn = 1'b1;
        drive1(1, mk(32'h31), 1, 0, 0);
        chk("reset_release_ready", e1_ready, 1);
        repeat (2) drive1(0, idle, 1, 0, 0);
        chk("reset_drained", q1.size(), 0);

        // single-entry build under random back-pressure
        idx = 0; n = 0;
        while (idx < 200 && n < 3000) begin
            p = mk(32'h100 + idx);
            e0_valid = 1'b1;
            {e0_wreg, e0_m2reg, e0_wmem} = p.ctrl;
            e0_alu = p.alu; e0_b = p.b; e0_rn = p.rn;
            m0_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("e_ready_comb", e0_ready, !m0_valid | m0_ready);
            if (e0_ready) begin
                q0.push_back(p);
                idx++;
            end
            @(posedge clock); #1;
            n++;
        end
        if (idx < 200) fail("nskid_timeout");
        e0_valid = 1'b0;
        m0_ready = 1'b1;
        n = 0;
        while (q0.size() != 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("nskid_drained", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
